hqm_assert_event_monitor: RTL and testbench

//  Consumes the per-event mismatch vector from the assert event checker. Start/end counts

---
 rtl/hqm_assert_pkg.sv | 16 +
 rtl/hqm_assert_event_monitor_chk.sv | 26 ++
 rtl/hqm_assert_persist_filter.sv | 49 ++++
 rtl/hqm_assert_event_monitor.sv | 131 +++++++++++++
 tb/tb_hqm_assert_event_monitor.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hqm_assert_pkg.sv
// Shared types and helpers for the assert event monitor: clear-handshake state
// encoding and the age counter width calculation.
package hqm_assert_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACK   = 2'd2
    } hqm_assert_clr_t;

    // Age counter must hold values 0..hold_cyc inclusive.
    function automatic int age_width(input int hold_cyc);
        return (hold_cyc < 1) ? 1 : $clog2(hold_cyc + 1);
    endfunction

endpackage

// File: rtl/hqm_assert_event_monitor_chk.sv
// Property checker bound into the event monitor: input consistency, handshake
// state coherence and single-cycle irq.
module hqm_assert_event_monitor_chk
    import hqm_assert_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic            clk,
    input logic            rst,
    input logic            error_v,
    input logic [WIDTH-1:0] error_event,
    input logic            clr_ack,
    input hqm_assert_clr_t state,
    input logic            irq
);

    a_error_v_summary: assert property (@(posedge clk) disable iff (rst)
        error_v == (|error_event));

    a_ack_in_ack_state: assert property (@(posedge clk) disable iff (rst)
        clr_ack |-> (state == ACK));

    a_irq_one_shot: assert property (@(posedge clk) disable iff (rst)
        irq |=> !irq);

endmodule

// File: rtl/hqm_assert_persist_filter.sv
// Persistence filter for one event stream: counts consecutive mismatch cycles and
// pulses qual exactly once per run when the run reaches HOLD_CYC cycles.
module hqm_assert_persist_filter
    import hqm_assert_pkg::*;
#(
    parameter int HOLD_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic err_in,
    input  logic wipe,
    output logic qual
);

    localparam int AGE_W = age_width(HOLD_CYC);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(HOLD_CYC);
    localparam logic [AGE_W-1:0] AGE_QUAL = AGE_W'(HOLD_CYC - 1);

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    // Saturating at AGE_MAX keeps a long run from wrapping back into a second qualify.
    always_comb begin
        age_d = '0;
        if (wipe) begin
            age_d = '0;
        end else if (enable && err_in) begin
            if (age_q == AGE_MAX) begin
                age_d = age_q;
            end else begin
                age_d = age_q + AGE_W'(1);
            end
        end else begin
            age_d = '0;
        end
    end

    assign qual = enable & err_in & ~wipe & (age_q == AGE_QUAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/hqm_assert_event_monitor.sv
// Qualifies persistent per-stream mismatches into sticky faults with a first-fault
// snapshot, saturating qualify counter, one-shot irq and req/ack software clear.
module hqm_assert_event_monitor
    import hqm_assert_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int HOLD_CYC = 64,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             error_v,
    input  logic [WIDTH-1:0] error_event,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             fault_v,
    output logic [WIDTH-1:0] fault_vec,
    output logic [WIDTH-1:0] first_vec,
    output logic [CNT_W-1:0] fault_cnt,
    output logic             irq
);

    logic [WIDTH-1:0] qual_s;
    logic             wipe_s;
    logic             any_qual_s;

    hqm_assert_clr_t  state_q, state_d;
    logic [WIDTH-1:0] fault_vec_q, fault_vec_d;
    logic [WIDTH-1:0] first_vec_q, first_vec_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic             fault_v_q, fault_v_d;
    logic             irq_q, irq_d;
    logic             clr_ack_q, clr_ack_d;

    assign wipe_s     = (state_q == CLEAR);
    assign any_qual_s = |qual_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_filter
        hqm_assert_persist_filter #(
            .HOLD_CYC(HOLD_CYC)
        ) u_filter (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .err_in (error_event[i]),
            .wipe   (wipe_s),
            .qual   (qual_s[i])
        );
    end

    // Clear handshake and capture; a capture in the cycle clr_req arrives is wiped by CLEAR next.
    always_comb begin
        state_d     = state_q;
        fault_vec_d = fault_vec_q;
        first_vec_d = first_vec_q;
        fault_cnt_d = fault_cnt_q;
        irq_d       = 1'b0;

        case (state_q)
            IDLE:    state_d = clr_req ? CLEAR : IDLE;
            CLEAR:   state_d = ACK;
            ACK:     state_d = clr_req ? ACK : IDLE;
            default: state_d = IDLE;
        endcase

        if (wipe_s) begin
            fault_vec_d = '0;
            first_vec_d = '0;
            fault_cnt_d = '0;
            irq_d       = 1'b0;
        end else begin
            fault_vec_d = fault_vec_q | qual_s;
            if (any_qual_s && !fault_v_q) begin
                first_vec_d = qual_s;
                irq_d       = 1'b1;
            end else begin
                first_vec_d = first_vec_q;
                irq_d       = 1'b0;
            end
            if (any_qual_s && (fault_cnt_q != {CNT_W{1'b1}})) begin
                fault_cnt_d = fault_cnt_q + CNT_W'(1);
            end else begin
                fault_cnt_d = fault_cnt_q;
            end
        end

        fault_v_d = |fault_vec_d;
        clr_ack_d = (state_d == ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fault_vec_q <= '0;
            first_vec_q <= '0;
            fault_cnt_q <= '0;
            fault_v_q   <= 1'b0;
            irq_q       <= 1'b0;
            clr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fault_vec_q <= fault_vec_d;
            first_vec_q <= first_vec_d;
            fault_cnt_q <= fault_cnt_d;
            fault_v_q   <= fault_v_d;
            irq_q       <= irq_d;
            clr_ack_q   <= clr_ack_d;
        end
    end

    assign clr_ack   = clr_ack_q;
    assign fault_v   = fault_v_q;
    assign fault_vec = fault_vec_q;
    assign first_vec = first_vec_q;
    assign fault_cnt = fault_cnt_q;
    assign irq       = irq_q;

    hqm_assert_event_monitor_chk #(
        .WIDTH(WIDTH)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .error_v     (error_v),
        .error_event (error_event),
        .clr_ack     (clr_ack_q),
        .state       (state_q),
        .irq         (irq_q)
    );

endmodule

// File: tb/tb_hqm_assert_event_monitor.sv
// Bench for hqm_assert_event_monitor (WIDTH=4, HOLD_CYC=8, CNT_W=4): table-driven
// pulse vectors plus hand sequences, checked through a cycle-stamped scoreboard.
module tb_hqm_assert_event_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       error_v;
    logic [3:0] error_event;
    logic       clr_req;
    logic       clr_ack;
    logic       fault_v;
    logic [3:0] fault_vec;
    logic [3:0] first_vec;
    logic [3:0] fault_cnt;
    logic       irq;

    always #5 clk = ~clk;
    assign error_v = |error_event;

    hqm_assert_event_monitor #(
        .WIDTH(4), .HOLD_CYC(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .error_v(error_v),
        .error_event(error_event), .clr_req(clr_req), .clr_ack(clr_ack),
        .fault_v(fault_v), .fault_vec(fault_vec), .first_vec(first_vec),
        .fault_cnt(fault_cnt), .irq(irq)
    );

    typedef struct {
        int         at;
        string      name;
        logic [3:0] fv;
        logic [3:0] first;
        logic [3:0] cnt;
        logic       irq_e;
        logic       ack_e;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         len;
        logic [3:0] fv;
        logic [3:0] first;
        logic [3:0] cnt;
        logic       irq_e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[5];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   irq_seen = 0;

    task automatic push(input int at, input string name, input logic [3:0] fv,
                        input logic [3:0] first, input logic [3:0] cnt,
                        input logic irq_e, input logic ack_e);
        exp_t e;
        int   idx;
        e.at = at; e.name = name; e.fv = fv; e.first = first;
        e.cnt = cnt; e.irq_e = irq_e; e.ack_e = ack_e;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s: check cycle %0d passed unchecked (now %0d)", e.name, e.at, cyc);
            end else if (fault_vec !== e.fv || first_vec !== e.first || fault_cnt !== e.cnt ||
                         fault_v !== (|e.fv) || irq !== e.irq_e || clr_ack !== e.ack_e) begin
                errors++;
                $display("FAIL %s @%0d: got vec=%b first=%b cnt=%h v=%b irq=%b ack=%b, expected vec=%b first=%b cnt=%h v=%b irq=%b ack=%b",
                         e.name, cyc, fault_vec, first_vec, fault_cnt, fault_v, irq, clr_ack,
                         e.fv, e.first, e.cnt, |e.fv, e.irq_e, e.ack_e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (irq === 1'b1) irq_seen++;
        sb_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        chk("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic do_clear();
        int n = 0;
        clr_req = 1'b1;
        while (clr_ack !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("clr_ack_rise", int'(clr_ack), 1);
        clr_req = 1'b0;
        n = 0;
        while (clr_ack !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("clr_ack_fall", int'(clr_ack), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int d;
        int irq_before;

        tbl[0] = '{mask: 4'b0001, len: 7,  fv: 4'b0000, first: 4'b0000, cnt: 4'h0, irq_e: 1'b0};
        tbl[1] = '{mask: 4'b0100, len: 8,  fv: 4'b0100, first: 4'b0100, cnt: 4'h1, irq_e: 1'b1};
        tbl[2] = '{mask: 4'b1010, len: 12, fv: 4'b1010, first: 4'b1010, cnt: 4'h1, irq_e: 1'b1};
        tbl[3] = '{mask: 4'b1111, len: 8,  fv: 4'b1111, first: 4'b1111, cnt: 4'h1, irq_e: 1'b1};
        tbl[4] = '{mask: 4'b0010, len: 1,  fv: 4'b0000, first: 4'b0000, cnt: 4'h0, irq_e: 1'b0};

        rst = 1'b1; enable = 1'b1; error_event = 4'b0000; clr_req = 1'b0;
        ticks(3);
        push(cyc, "reset_state", 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        ticks(2);

        // Table: one run per row from a cleared state; check just before, at, and after qualify.
        for (int r = 0; r < 5; r++) begin
            do_clear();
            c = cyc;
            error_event = tbl[r].mask;
            push(c + 7, $sformatf("row%0d_pre", r), 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
            push(c + 8, $sformatf("row%0d_hit", r), tbl[r].fv, tbl[r].first, tbl[r].cnt, tbl[r].irq_e, 1'b0);
            push(c + 9, $sformatf("row%0d_after", r), tbl[r].fv, tbl[r].first, tbl[r].cnt, 1'b0, 1'b0);
            ticks(tbl[r].len);
            error_event = 4'b0000;
            drain();
        end

        // Later qualify on another bit keeps first_vec and raises no second irq.
        do_clear();
        irq_before = irq_seen;
        c = cyc;
        error_event = 4'b1010;
        push(c + 8,  "t3_first",  4'b1010, 4'b1010, 4'h1, 1'b1, 1'b0);
        push(c + 18, "t3_second", 4'b1011, 4'b1010, 4'h2, 1'b0, 1'b0);
        push(c + 19, "t3_after",  4'b1011, 4'b1010, 4'h2, 1'b0, 1'b0);
        ticks(10);
        error_event = 4'b1011;
        ticks(12);
        drain();
        error_event = 4'b0000;
        chk("t3_irq_pulses", irq_seen - irq_before, 1);

        // Saturating counter over 20 separate qualifying pulses.
        do_clear();
        for (int k = 1; k <= 20; k++) begin
            c = cyc;
            error_event = 4'b0001;
            push(c + 8, $sformatf("t4_pulse%0d", k), 4'b0001, 4'b0001,
                 (k > 15) ? 4'hF : 4'(k), (k == 1), 1'b0);
            ticks(8);
            error_event = 4'b0000;
            tick();
        end
        drain();

        // Clear while bit0 stays high; it re-qualifies after fresh aging.
        do_clear();
        c = cyc;
        error_event = 4'b0001;
        push(c + 8, "t5_set", 4'b0001, 4'b0001, 4'h1, 1'b1, 1'b0);
        ticks(10);
        d = cyc;
        clr_req = 1'b1;
        push(d + 2,  "t5_cleared",   4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1);
        push(d + 3,  "t5_ack_held",  4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1);
        push(d + 4,  "t5_ack_drop",  4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        push(d + 9,  "t5_pre_requal",4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        push(d + 10, "t5_requal",    4'b0001, 4'b0001, 4'h1, 1'b1, 1'b0);
        ticks(3);
        clr_req = 1'b0;
        ticks(10);
        drain();
        error_event = 4'b0000;

        // enable dropped at age 5: qualify needs a fresh 8-cycle run.
        do_clear();
        c = cyc;
        error_event = 4'b0010;
        push(c + 8,  "t6_en_old_time", 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        push(c + 14, "t6_en_pre",      4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        push(c + 15, "t6_en_qual",     4'b0010, 4'b0010, 4'h1, 1'b1, 1'b0);
        ticks(5);
        enable = 1'b0;
        ticks(2);
        enable = 1'b1;
        ticks(10);
        drain();

        // rst at age 5 wipes the existing fault and restarts aging.
        error_event = 4'b0000;
        ticks(2);
        c = cyc;
        error_event = 4'b0010;
        push(c + 5,  "t6_rst_before", 4'b0010, 4'b0010, 4'h1, 1'b0, 1'b0);
        push(c + 6,  "t6_rst_zero",   4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        push(c + 13, "t6_rst_pre",    4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        push(c + 14, "t6_rst_qual",   4'b0010, 4'b0010, 4'h1, 1'b1, 1'b0);
        ticks(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(10);
        drain();

        // rst during the ACK phase of a handshake.
        error_event = 4'b0000;
        tick();
        c = cyc;
        clr_req = 1'b1;
        push(c + 2, "hs_ack",    4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1);
        push(c + 4, "hs_rst",    4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0);
        ticks(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_req = 1'b0;
        tick();
        drain();

        ticks(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
